mc_ctrl_fsm: RTL and testbench

Multicycle main control unit for the MIPS-subset CPU datapath. It decodes the 6-bit opcode held in the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback states. Each cycle it drives the select lines of the datapath's 2:1 and 4:1 selectors (IorD, ALUSrcA, MemtoReg, RegDst, ALUSrcB, PCSource) and all write enables. Memory accesses stall on a ready handshake.

---
 rtl/mc_ctrl_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle main control unit for a MIPS-subset datapath. Sequences each
// instruction through fetch, decode, execute, memory and writeback states and
// drives the datapath selectors and write enables every cycle. Memory phases
// (IF, MRD, MWR) stall on mem_ready.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   op           in   opcode IR[31:26], sampled in ID and MA only
//   mem_ready    in   memory completes the current access this cycle
//   PCWrite      out  unconditional PC write enable
//   PCWriteCond  out  PC write enable qualified by ALU zero (beq)
//   IorD         out  memory address select: 0 = PC, 1 = ALUOut
//   MemRead      out  memory read request
//   MemWrite     out  memory write request
//   IRWrite      out  instruction register load
//   MemtoReg     out  register write data: 0 = ALUOut, 1 = MDR
//   RegDst       out  destination register: 0 = rt, 1 = rd
//   RegWrite     out  register file write enable
//   ALUSrcA      out  ALU A: 0 = PC, 1 = register A
//   ALUSrcB      out  ALU B: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2
//   ALUOp        out  00 = add, 01 = sub, 10 = funct field
//   PCSource     out  00 = ALU result, 01 = ALUOut, 10 = jump address
//   state        out  current state (debug)
//   illegal      out  one-cycle pulse when an undefined opcode is decoded
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
   parameter int unsigned OP_W = 6,
   parameter int unsigned ST_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output logic            PCWrite,
   output logic            PCWriteCond,
   output logic            IorD,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            MemtoReg,
   output logic            RegDst,
   output logic            RegWrite,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [1:0]      ALUOp,
   output logic [1:0]      PCSource,
   output logic [ST_W-1:0] state,
   output logic            illegal
);

   localparam logic [OP_W-1:0] OpRtype = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OpLw    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OpSw    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OpBeq   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OpJ     = OP_W'(6'b000010);
   localparam logic [OP_W-1:0] OpAddi  = OP_W'(6'b001000);

   typedef enum logic [ST_W-1:0] {
      StIf  = ST_W'(0),
      StId  = ST_W'(1),
      StMa  = ST_W'(2),
      StMrd = ST_W'(3),
      StWbl = ST_W'(4),
      StMwr = ST_W'(5),
      StExr = ST_W'(6),
      StWbr = ST_W'(7),
      StBeq = ST_W'(8),
      StJmp = ST_W'(9),
      StExi = ST_W'(10),
      StWbi = ST_W'(11),
      StIll = ST_W'(12)
   } state_e;

   state_e r_state;

   // State register; encodings 13-15 fall into the default and recover to IF.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIf;
      end else begin
         case (r_state)
            StIf:  r_state <= mem_ready ? StId : StIf;
            StId: begin
               if (op == OpLw || op == OpSw) r_state <= StMa;
               else if (op == OpRtype)       r_state <= StExr;
               else if (op == OpBeq)         r_state <= StBeq;
               else if (op == OpJ)           r_state <= StJmp;
               else if (op == OpAddi)        r_state <= StExi;
               else                          r_state <= StIll;
            end
            StMa: begin
               if (op == OpLw)      r_state <= StMrd;
               else if (op == OpSw) r_state <= StMwr;
               else                 r_state <= StIf;
            end
            StMrd: r_state <= mem_ready ? StWbl : StMrd;
            StWbl: r_state <= StIf;
            StMwr: r_state <= mem_ready ? StIf : StMwr;
            StExr: r_state <= StWbr;
            StWbr: r_state <= StIf;
            StBeq: r_state <= StIf;
            StJmp: r_state <= StIf;
            StExi: r_state <= StWbi;
            StWbi: r_state <= StIf;
            StIll: r_state <= StIf;
            default: r_state <= StIf;
         endcase
      end
   end

   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic       w_iord;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_mem_to_reg;
   logic       w_reg_dst;
   logic       w_reg_write;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_op;
   logic [1:0] w_pc_source;
   logic       w_illegal;

   always_comb begin
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_iord          = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_reg_dst       = 1'b0;
      w_reg_write     = 1'b0;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = 2'b00;
      w_alu_op        = 2'b00;
      w_pc_source     = 2'b00;
      w_illegal       = 1'b0;
      case (r_state)
         StIf: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = 2'b01;
            w_ir_write  = mem_ready;
            w_pc_write  = mem_ready;
         end
         StId: w_alu_src_b = 2'b11;
         StMa: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
         end
         StMrd: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
         end
         StWbl: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
         end
         StMwr: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
         end
         StExr: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = 2'b10;
         end
         StWbr: begin
            w_reg_write = 1'b1;
            w_reg_dst   = 1'b1;
         end
         StBeq: begin
            w_alu_src_a     = 1'b1;
            w_alu_op        = 2'b01;
            w_pc_write_cond = 1'b1;
            w_pc_source     = 2'b01;
         end
         StJmp: begin
            w_pc_write  = 1'b1;
            w_pc_source = 2'b10;
         end
         StExi: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
         end
         StWbi: w_reg_write = 1'b1;
         StIll: w_illegal = 1'b1;
         default: ;
      endcase
   end

   // Enables are gated by rst_n so an asynchronous reset kills any write in
   // the same instant, before the state register has even been observed.
   // Reset state is IF, whose selects already match the required reset values.
   assign PCWrite     = w_pc_write      & rst_n;
   assign PCWriteCond = w_pc_write_cond & rst_n;
   assign MemRead     = w_mem_read      & rst_n;
   assign MemWrite    = w_mem_write     & rst_n;
   assign IRWrite     = w_ir_write      & rst_n;
   assign RegWrite    = w_reg_write     & rst_n;
   assign illegal     = w_illegal       & rst_n;
   assign IorD        = w_iord;
   assign MemtoReg    = w_mem_to_reg;
   assign RegDst      = w_reg_dst;
   assign ALUSrcA     = w_alu_src_a;
   assign ALUSrcB     = w_alu_src_b;
   assign ALUOp       = w_alu_op;
   assign PCSource    = w_pc_source;
   assign state       = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Scoreboard bench for mc_ctrl_fsm. The stimulus process plays instructions
// cycle by cycle and pushes the expected state/outputs for each cycle; a
// monitor on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

   typedef struct packed {
      logic       pcw;
      logic       pcwc;
      logic       iord;
      logic       mrd;
      logic       mwr;
      logic       irw;
      logic       m2r;
      logic       rdst;
      logic       rw;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       ill;
   } outs_t;

   typedef struct packed {
      logic [3:0] st;
      outs_t      o;
   } exp_t;

   localparam logic [5:0] OpR   = 6'b000000;
   localparam logic [5:0] OpLw  = 6'b100011;
   localparam logic [5:0] OpSw  = 6'b101011;
   localparam logic [5:0] OpBeq = 6'b000100;
   localparam logic [5:0] OpJ   = 6'b000010;
   localparam logic [5:0] OpAdi = 6'b001000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];
   bit   sb_en    = 1'b0;

   mc_ctrl_fsm #(.OP_W(6), .ST_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .op          (op),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemtoReg    (MemtoReg),
      .RegDst      (RegDst),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .PCSource    (PCSource),
      .state       (state),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   function automatic outs_t dut_outs();
      outs_t o;
      o = '{pcw: PCWrite, pcwc: PCWriteCond, iord: IorD, mrd: MemRead, mwr: MemWrite,
            irw: IRWrite, m2r: MemtoReg, rdst: RegDst, rw: RegWrite, srca: ALUSrcA,
            srcb: ALUSrcB, aluop: ALUOp, pcsrc: PCSource, ill: illegal};
      return o;
   endfunction

   // Reference: control word of each named step of an instruction.
   function automatic outs_t ref_outs(input int st, input logic mr);
      outs_t o;
      o = '0;
      case (st)
         0:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end   // fetch
         1:  o.srcb = 2'b11;                                              // decode
         2:  begin o.srca = 1; o.srcb = 2'b10; end                        // address
         3:  begin o.mrd = 1; o.iord = 1; end                             // mem read
         4:  begin o.rw = 1; o.m2r = 1; end                               // lw wb
         5:  begin o.mwr = 1; o.iord = 1; end                             // mem write
         6:  begin o.srca = 1; o.aluop = 2'b10; end                       // R exec
         7:  begin o.rw = 1; o.rdst = 1; end                              // R wb
         8:  begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 2'b01; end
         9:  begin o.pcw = 1; o.pcsrc = 2'b10; end
         10: begin o.srca = 1; o.srcb = 2'b10; end                        // addi exec
         11: o.rw = 1;                                                    // addi wb
         12: o.ill = 1;
         default: ;
      endcase
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at posedge+1: drive one cycle, record its expectation, advance.
   task automatic cyc(input int st, input logic mr, input logic [5:0] opv);
      exp_t e;
      mem_ready = mr;
      op        = opv;
      e.st      = 4'(st);
      e.o       = ref_outs(st, mr);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] rnd_op();
      return 6'($urandom);
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom);
   endfunction

   task automatic run_instr(input logic [5:0] opc, input int s_if, input int s_mem);
      for (int i = 0; i < s_if; i++) cyc(0, 1'b0, rnd_op());
      cyc(0, 1'b1, rnd_op());
      cyc(1, rnd_bit(), opc);
      case (opc)
         OpLw: begin
            cyc(2, rnd_bit(), opc);
            for (int i = 0; i < s_mem; i++) cyc(3, 1'b0, rnd_op());
            cyc(3, 1'b1, rnd_op());
            cyc(4, rnd_bit(), rnd_op());
         end
         OpSw: begin
            cyc(2, rnd_bit(), opc);
            for (int i = 0; i < s_mem; i++) cyc(5, 1'b0, rnd_op());
            cyc(5, 1'b1, rnd_op());
         end
         OpR: begin
            cyc(6, rnd_bit(), rnd_op());
            cyc(7, rnd_bit(), rnd_op());
         end
         OpAdi: begin
            cyc(10, rnd_bit(), rnd_op());
            cyc(11, rnd_bit(), rnd_op());
         end
         OpBeq: cyc(8, rnd_bit(), rnd_op());
         OpJ:   cyc(9, rnd_bit(), rnd_op());
         default: cyc(12, rnd_bit(), rnd_op());
      endcase
   endtask

   always @(negedge clk) begin
      if (sb_en) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: no expectation queued at %0t", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("outputs", 32'(dut_outs()), 32'(e.o));
            chk("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
         end
      end
   end

   outs_t rst_outs;
   logic [5:0] pick;
   logic [5:0] legal [6] = '{OpR, OpLw, OpSw, OpBeq, OpJ, OpAdi};

   initial begin
      rst_outs      = '0;
      rst_outs.srcb = 2'b01;
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      op        = OpR;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_outs", 32'(dut_outs()), 32'(rst_outs));

      // Walk an R-type into EXR, then assert reset mid-cycle.
      rst_n = 1'b1;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      op = OpR;
      @(posedge clk); #1;
      chk("exr_reached", 32'(state), 32'd6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_outs", 32'(dut_outs()), 32'(rst_outs));
      @(posedge clk); #1;
      chk("rst_hold_state", 32'(state), 32'd0);
      rst_n = 1'b1;
      sb_en = 1'b1;

      run_instr(OpLw, 0, 0);
      run_instr(OpSw, 0, 3);
      run_instr(OpLw, 2, 0);
      run_instr(OpR, 0, 0);
      run_instr(OpAdi, 0, 0);
      run_instr(OpBeq, 0, 0);
      run_instr(OpJ, 0, 0);
      run_instr(6'b111111, 0, 0);

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 6) == 0) begin
            do pick = rnd_op();
            while (pick inside {OpR, OpLw, OpSw, OpBeq, OpJ, OpAdi});
         end else begin
            pick = legal[$urandom_range(0, 5)];
         end
         run_instr(pick, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      sb_en = 1'b0;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
